// File: rtl/mac_pkg.sv
// mac_pkg: shared types, latency constant and saturating-add helper for the
// mac_pipe_acc multiply-accumulate unit.
// The widths below are the default configuration of mac_pipe_acc. sat_add
// works on a 64-bit signed carrier, so one helper serves any ACC_W up to 63.
package mac_pkg;

    localparam int MAC_IN_W        = 14;
    localparam int MAC_ACC_W       = 28;
    localparam int MAC_MULT_STAGES = 6;
    // Sampling edge of valid_in to the edge that presents f/valid_out.
    localparam int LATENCY         = MAC_MULT_STAGES + 2;
    localparam int SAT_W           = 64;

    typedef logic signed [MAC_IN_W-1:0]   operand_t;
    typedef logic signed [2*MAC_IN_W-1:0] product_t;
    typedef logic signed [MAC_ACC_W-1:0]  acc_t;
    typedef logic signed [SAT_W-1:0]      sat_word_t;

    typedef struct packed {
        sat_word_t sum;   // clamped sum, valid in the low acc_w bits
        logic      hit;   // the raw sum left the acc_w range
    } sat_res_t;

    // Add two sign-extended values and clamp the sum to a signed acc_w range.
    function automatic sat_res_t sat_add(input sat_word_t acc,
                                         input sat_word_t prod,
                                         input int        acc_w);
        sat_res_t  res;
        sat_word_t sum;
        sat_word_t max_v;
        sat_word_t min_v;
        sum   = acc + prod;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (sum > max_v) begin
            res.sum = max_v;
            res.hit = 1'b1;
        end else if (sum < min_v) begin
            res.sum = min_v;
            res.hit = 1'b1;
        end else begin
            res.sum = sum;
            res.hit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_pipe_acc_pipe_mult.sv
// pipe_mult: signed multiplier followed by MULT_STAGES-1 retiming registers,
// with a tag shift register that stays aligned to the product.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             synchronous: invalidate every tag (product regs keep running)
//   a, b              signed operands (held stable by the caller between terms)
//   tag_in            validity tag entering alongside a/b
//   prod, tag_out     product and tag after MULT_STAGES registers
module pipe_mult #(
    parameter int IN_W        = 14,
    parameter int MULT_STAGES = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic signed [IN_W-1:0]     a,
    input  logic signed [IN_W-1:0]     b,
    input  logic                       tag_in,
    output logic signed [2*IN_W-1:0]   prod,
    output logic                       tag_out
);

    localparam int PROD_W = 2 * IN_W;

    logic signed [PROD_W-1:0] prod_q [MULT_STAGES];
    logic signed [PROD_W-1:0] prod_d [MULT_STAGES];
    logic [MULT_STAGES-1:0]   tag_q;
    logic [MULT_STAGES-1:0]   tag_d;

    // Product path is free-running; tags shift with it and are zeroed by flush.
    always_comb begin
        prod_d[0] = PROD_W'(a) * PROD_W'(b);
        tag_d[0]  = tag_in & ~flush;
        for (int i = 1; i < MULT_STAGES; i++) begin
            prod_d[i] = prod_q[i-1];
            tag_d[i]  = tag_q[i-1] & ~flush;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                prod_q[i] <= '0;
            end
            tag_q <= '0;
        end else begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            tag_q <= tag_d;
        end
    end

    assign prod    = prod_q[MULT_STAGES-1];
    assign tag_out = tag_q[MULT_STAGES-1];

endmodule

// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: pipelined signed multiply-accumulate with saturation and
// optional NUM_TERMS-term grouping (NUM_TERMS=0 gives a running sum).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   a, b            signed IN_W operands, sampled when valid_in=1
//   valid_in        term valid this cycle
//   clear           synchronous flush of in-flight terms, acc and term counter
//   f               signed ACC_W result, held between valid_out pulses
//   valid_out       one-cycle pulse marking a new f
//   sat_flag        sticky saturation flag (only when MAC_SAT_FLAG_EN is defined)
// Pipeline: operand regs -> pipe_mult (MULT_STAGES) -> accumulate -> output regs.
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int IN_W        = MAC_IN_W,
    parameter int ACC_W       = MAC_ACC_W,
    parameter int MULT_STAGES = MAC_MULT_STAGES,
    parameter int NUM_TERMS   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out
`ifdef MAC_SAT_FLAG_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int PROD_W = 2 * IN_W;
    localparam int CNT_W  = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

    if (ACC_W < 2 * IN_W) begin : g_acc_w_check
        $error("mac_pipe_acc: ACC_W must be >= 2*IN_W");
    end
    if (ACC_W >= SAT_W) begin : g_acc_w_max_check
        $error("mac_pipe_acc: ACC_W must be < 64");
    end
    if (MULT_STAGES < 1) begin : g_stages_check
        $error("mac_pipe_acc: MULT_STAGES must be >= 1");
    end

    logic signed [IN_W-1:0]   a_q, a_d, b_q, b_d;
    logic                     tag0_q, tag0_d;
    logic signed [PROD_W-1:0] prod_s;
    logic                     tag_s;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     emit_q, emit_d;
    logic signed [ACC_W-1:0]  f_q, f_d;
    logic                     valid_out_q, valid_out_d;
    logic                     first_s, last_s;
    sat_res_t                 sat_s;
    logic                     unused_sat_s;

    // Stage 0: operands load only on valid terms; the tag is pushed every edge.
    always_comb begin
        if (valid_in) begin
            a_d = a;
            b_d = b;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
        tag0_d = valid_in & ~clear;
    end

    // Stage 0 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            tag0_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            tag0_q <= tag0_d;
        end
    end

    pipe_mult #(
        .IN_W        (IN_W),
        .MULT_STAGES (MULT_STAGES)
    ) u_pipe_mult (
        .clk     (clk),
        .reset   (reset),
        .flush   (clear),
        .a       (a_q),
        .b       (b_q),
        .tag_in  (tag0_q),
        .prod    (prod_s),
        .tag_out (tag_s)
    );

    // Accumulate stage: first term of a group loads, later terms add with clamp.
    always_comb begin
        sat_s   = sat_add(sat_word_t'(acc_q), sat_word_t'(prod_s), ACC_W);
        first_s = (NUM_TERMS > 0) && (cnt_q == '0);
        last_s  = (NUM_TERMS == 0) || (cnt_q == CNT_W'(NUM_TERMS - 1));
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        emit_d  = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (tag_s) begin
            if (first_s) begin
                acc_d = ACC_W'(prod_s);
            end else begin
                acc_d = sat_s.sum[ACC_W-1:0];
            end
            if (NUM_TERMS == 0) begin
                cnt_d = cnt_q;
            end else if (last_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            emit_d = last_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // High carrier bits are never needed once the sum is clamped.
    assign unused_sat_s = ^{sat_s.sum[SAT_W-1:ACC_W], sat_s.hit};

    // Accumulate stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            emit_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            emit_q <= emit_d;
        end
    end

    // Output stage: publish the finished sum; clear suppresses a pending pulse.
    always_comb begin
        f_d         = f_q;
        valid_out_d = 1'b0;
        if (clear) begin
            valid_out_d = 1'b0;
        end else if (emit_q) begin
            f_d         = acc_q;
            valid_out_d = 1'b1;
        end else begin
            valid_out_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q         <= '0;
            valid_out_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign f         = f_q;
    assign valid_out = valid_out_q;

`ifdef MAC_SAT_FLAG_EN
    logic term_q, term_d, first_q, first_d, hit_q, hit_d;
    logic sat_flag_q, sat_flag_d;

    // Per-term saturation info, carried one stage so the flag lines up with f.
    always_comb begin
        term_d  = tag_s & ~clear;
        first_d = tag_s & ~clear & first_s;
        hit_d   = tag_s & ~clear & ~first_s & sat_s.hit;
    end

    // Sticky flag: a new group restarts it, any saturating term sets it.
    always_comb begin
        sat_flag_d = sat_flag_q;
        if (clear) begin
            sat_flag_d = 1'b0;
        end else if (term_q) begin
            if (first_q) begin
                sat_flag_d = hit_q;
            end else begin
                sat_flag_d = sat_flag_q | hit_q;
            end
        end else begin
            sat_flag_d = sat_flag_q;
        end
    end

    // Saturation flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            term_q     <= 1'b0;
            first_q    <= 1'b0;
            hit_q      <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            term_q     <= term_d;
            first_q    <= first_d;
            hit_q      <= hit_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Self-checking bench for mac_pipe_acc: one running-sum instance (NUM_TERMS=0)
// and one grouped instance (NUM_TERMS=4) share the same stimulus. A
// transaction-level model (queue of terms stamped with their output edge)
// predicts f, valid_out and, with MAC_SAT_FLAG_EN, sat_flag for both.
module tb_mac_pipe_acc;
    import mac_pkg::*;

    localparam int  IN_W  = 14;
    localparam int  ACC_W = 28;
    localparam longint MAXV = 64'sd134217727;
    localparam longint MINV = -64'sd134217728;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [IN_W-1:0] a = '0;
    logic signed [IN_W-1:0] b = '0;
    logic valid_in = 1'b0;
    logic clear = 1'b0;
    logic signed [ACC_W-1:0] f_run, f_grp;
    logic vo_run, vo_grp;
`ifdef MAC_SAT_FLAG_EN
    logic sat_run, sat_grp;
`endif

    always #5 clk = ~clk;

    mac_pipe_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_STAGES(6), .NUM_TERMS(0)) dut_run (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
        .f(f_run), .valid_out(vo_run)
`ifdef MAC_SAT_FLAG_EN
        , .sat_flag(sat_run)
`endif
    );

    mac_pipe_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_STAGES(6), .NUM_TERMS(4)) dut_grp (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear(clear),
        .f(f_grp), .valid_out(vo_grp)
`ifdef MAC_SAT_FLAG_EN
        , .sat_flag(sat_grp)
`endif
    );

    typedef struct { int oe; longint p; } term_t;
    term_t  pend[$];
    int     kterms[2] = '{0, 4};
    longint m_acc[2], m_f[2];
    int     m_cnt[2];
    bit     m_vo[2], m_sat[2];
    int     edge_n = 0;
    int     checks = 0;
    int     errors = 0;
    longint run_pf[$], grp_pf[$];
    int     run_pe[$];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_f[d] = 0; m_cnt[d] = 0; m_vo[d] = 1'b0; m_sat[d] = 1'b0;
        end
    endtask

    // Apply one accumulated term to model d.
    task automatic apply(input int d, input longint p);
        longint s;
        if (kterms[d] > 0 && m_cnt[d] == 0) begin
            m_acc[d] = p;
            m_sat[d] = 1'b0;
        end else begin
            s = m_acc[d] + p;
            if (s > MAXV) begin s = MAXV; m_sat[d] = 1'b1; end
            if (s < MINV) begin s = MINV; m_sat[d] = 1'b1; end
            m_acc[d] = s;
        end
        if (kterms[d] == 0) begin
            m_f[d] = m_acc[d]; m_vo[d] = 1'b1;
        end else begin
            m_cnt[d]++;
            if (m_cnt[d] == kterms[d]) begin
                m_f[d] = m_acc[d]; m_vo[d] = 1'b1; m_cnt[d] = 0;
            end
        end
    endtask

    task automatic model_edge(input bit v, input bit c, input longint p);
        term_t t;
        m_vo[0] = 1'b0; m_vo[1] = 1'b0;
        if (c) begin
            pend.delete();
            for (int d = 0; d < 2; d++) begin
                m_acc[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
            end
        end else if (pend.size() > 0 && pend[0].oe == edge_n) begin
            t = pend.pop_front();
            apply(0, t.p);
            apply(1, t.p);
        end
        if (v && !c) pend.push_back('{edge_n + LATENCY, p});
    endtask

    task automatic step(input int av, input int bv, input bit v, input bit c);
        a = av[IN_W-1:0]; b = bv[IN_W-1:0]; valid_in = v; clear = c;
        @(posedge clk);
        model_edge(v, c, longint'(av) * longint'(bv));
        #1;
        check("f_run", f_run, m_f[0]);
        check("vo_run", vo_run, m_vo[0]);
        check("f_grp", f_grp, m_f[1]);
        check("vo_grp", vo_grp, m_vo[1]);
`ifdef MAC_SAT_FLAG_EN
        check("sat_run", sat_run, m_sat[0]);
        check("sat_grp", sat_grp, m_sat[1]);
`endif
        if (vo_run) begin run_pf.push_back(f_run); run_pe.push_back(edge_n); end
        if (vo_grp) grp_pf.push_back(f_grp);
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    task automatic start_test();
        step(0, 0, 1'b0, 1'b1);
        run_pf.delete(); run_pe.delete(); grp_pf.delete();
    endtask

    // Assert reset between edges, check outputs drop at once, then release.
    task automatic async_reset();
        valid_in = 1'b0; clear = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rst_f_run", f_run, 0);
        check("rst_vo_run", vo_run, 0);
        check("rst_f_grp", f_grp, 0);
        check("rst_vo_grp", vo_grp, 0);
        @(posedge clk); edge_n++;
        @(posedge clk); edge_n++;
        #1 reset = 1'b0;
    endtask

    initial begin
        int s;
        int av, bv;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_f_run", f_run, 0);
        check("reset_vo_run", vo_run, 0);
        check("reset_f_grp", f_grp, 0);
        check("reset_vo_grp", vo_grp, 0);
        reset = 1'b0;

        // Running sum: (3,4) then (-2,5) back-to-back.
        run_pf.delete(); run_pe.delete(); grp_pf.delete();
        s = edge_n;
        step(3, 4, 1'b1, 1'b0);
        step(-2, 5, 1'b1, 1'b0);
        idle(10);
        check("rs_pulses", run_pf.size(), 2);
        if (run_pf.size() == 2) begin
            check("rs_f0", run_pf[0], 12);
            check("rs_f1", run_pf[1], 2);
            check("rs_lat0", run_pe[0] - s, 8);
            check("rs_lat1", run_pe[1] - s, 9);
        end
        check("rs_grp_nopulse", grp_pf.size(), 0);

        // Positive saturation.
        start_test();
        repeat (3) step(-8192, -8192, 1'b1, 1'b0);
        idle(10);
        check("psat_pulses", run_pf.size(), 3);
        if (run_pf.size() == 3) begin
            check("psat_f0", run_pf[0], 67108864);
            check("psat_f1", run_pf[1], 134217727);
            check("psat_f2", run_pf[2], 134217727);
        end
`ifdef MAC_SAT_FLAG_EN
        check("psat_flag", sat_run, 1);
`endif

        // Negative saturation.
        start_test();
`ifdef MAC_SAT_FLAG_EN
        check("clr_flag", sat_run, 0);
`endif
        repeat (3) step(-8192, 8191, 1'b1, 1'b0);
        idle(10);
        check("nsat_pulses", run_pf.size(), 3);
        if (run_pf.size() == 3) check("nsat_f2", run_pf[2], -134217728);

        // Groups of four: products 1..8 with an idle after the second term.
        start_test();
        step(1, 1, 1'b1, 1'b0);
        step(2, 1, 1'b1, 1'b0);
        idle(1);
        for (int i = 3; i <= 8; i++) step(i, 1, 1'b1, 1'b0);
        idle(10);
        check("grp_pulses", grp_pf.size(), 2);
        if (grp_pf.size() == 2) begin
            check("grp_f0", grp_pf[0], 10);
            check("grp_f1", grp_pf[1], 26);
        end

        // Clear coinciding with valid_in discards the partial group.
        start_test();
        repeat (2) step(1, 1, 1'b1, 1'b0);
        step(1, 1, 1'b1, 1'b1);
        repeat (4) step(1, 1, 1'b1, 1'b0);
        idle(10);
        check("clr_pulses", grp_pf.size(), 1);
        if (grp_pf.size() == 1) check("clr_f", grp_pf[0], 4);

        // Asynchronous reset in the middle of a group.
        start_test();
        repeat (2) step(2, 1, 1'b1, 1'b0);
        idle(3);
        async_reset();
        run_pf.delete(); grp_pf.delete();
        repeat (4) step(2, 1, 1'b1, 1'b0);
        idle(10);
        check("rst_grp_pulses", grp_pf.size(), 1);
        if (grp_pf.size() == 1) check("rst_grp_f", grp_pf[0], 8);
        check("rst_run_f", f_run, 8);

        // Randomized traffic with occasional clears and extreme operands.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                av = int'($urandom_range(16383, 0)) - 8192;
                bv = int'($urandom_range(16383, 0)) - 8192;
            end else begin
                av = ($urandom_range(1, 0) == 1) ? -8192 : 8191;
                bv = ($urandom_range(1, 0) == 1) ? -8192 : 8191;
            end
            step(av, bv, ($urandom_range(3, 0) != 0), ($urandom_range(24, 0) == 0));
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
